// File: rtl/fifo_sync_circular.sv
// Single-clock circular FIFO with show-ahead or registered-read output,
// almost-full/almost-empty thresholds, occupancy count, flush and sticky error flags.
module fifo_sync_circular #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst_in,
    input  logic                         flush_in,
    input  logic                         write_in,
    input  logic [WIDTH-1:0]             data_write_in,
    input  logic                         read_in,
    output logic [WIDTH-1:0]             data_read_out,
    output logic                         full_out,
    output logic                         empty_out,
    output logic                         almost_full_out,
    output logic                         almost_empty_out,
    output logic [$clog2(DEPTH):0]       count_out,
    output logic                         overflow_out,
    output logic                         underflow_out
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam logic [ADDR_W:0] AF_C = PTR_W'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C = PTR_W'(AE_THRESH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]   count;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              full, empty;
    logic              wr_acc, rd_acc;
    logic [ADDR_W-1:0] waddr, raddr;

    assign waddr = wptr_q[ADDR_W-1:0];
    assign raddr = rptr_q[ADDR_W-1:0];
    assign count = wptr_q - rptr_q;
    // Full: same slot address, opposite lap (wrap bit differs).
    assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) && (waddr == raddr);
    assign empty = (wptr_q == rptr_q);

    assign full_out         = full;
    assign empty_out        = empty;
    assign count_out        = count;
    assign almost_full_out  = (count >= AF_C);
    assign almost_empty_out = (count <= AE_C);
    assign overflow_out     = ovf_q;
    assign underflow_out    = udf_q;

    // Next-state for pointers and error flags; flush overrides traffic.
    always_comb begin
        wr_acc = 1'b0;
        rd_acc = 1'b0;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (flush_in) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            wr_acc = write_in && !full;
            rd_acc = read_in && !empty;
            wptr_d = wptr_q + PTR_W'(wr_acc);
            rptr_d = rptr_q + PTR_W'(rd_acc);
            ovf_d  = ovf_q || (write_in && full);
            udf_d  = udf_q || (read_in && empty);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst_in && wr_acc) begin
            mem_q[waddr] <= data_write_in;
        end
    end

    if (FWFT != 0) begin : g_show_ahead
        assign data_read_out = empty ? '0 : mem_q[raddr];
    end else begin : g_registered
        logic [WIDTH-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (rst_in) begin
                rdata_q <= '0;
            end else if (rd_acc) begin
                rdata_q <= mem_q[raddr];
            end
        end
        assign data_read_out = rdata_q;
    end

endmodule

// File: doc/fifo_sync_circular.md
# fifo_sync_circular

Single-clock circular-buffer FIFO, the parametrised successor to the team's asynchronous circular FIFO, for paths where producer and consumer share one clock. Adds selectable show-ahead (first-word-fall-through) or registered-read mode, programmable almost-full/almost-empty thresholds, an occupancy count, synchronous flush, and sticky overflow/underflow error flags. Used as the standard elastic buffer between same-clock pipeline stages (UART/SPI byte queues, DMA staging).

## Interface
- DEPTH, 16: number of entries; power of two, ≥ 2; ADDR_W = log2(DEPTH)
- WIDTH, 8: data width in bits, ≥ 1
- FWFT, 0: 0 = registered-read mode, 1 = show-ahead mode
- AF_THRESH, DEPTH-2: almost_full_out asserts when count ≥ AF_THRESH; range 1..DEPTH
- AE_THRESH, 2: almost_empty_out asserts when count ≤ AE_THRESH; range 0..DEPTH-1

- clk  input  1  single clock; all state updates on the rising edge
- rst_in  input  1  reset; synchronous, active-high
- flush_in  input  1  synchronous flush: empties the FIFO and clears the error flags
- write_in  input  1  write request
- data_write_in  input  WIDTH  write data
- read_in  input  1  read request (show-ahead mode: acknowledge of the head word)
- data_read_out  output  WIDTH  read data
- full_out  output  1  count == DEPTH
- empty_out  output  1  count == 0
- almost_full_out  output  1  count ≥ AF_THRESH
- almost_empty_out  output  1  count ≤ AE_THRESH
- count_out  output  ADDR_W+1  occupancy, 0..DEPTH
- overflow_out  output  1  sticky: a write was attempted while full
- underflow_out  output  1  sticky: a read was attempted while empty

## Operation
- Storage: DEPTH×WIDTH array, not reset. Write pointer and read pointer are ADDR_W+1 bits each, and the MSB is the wrap bit. Address = low ADDR_W bits. count_out = wptr − rptr, computed modulo 2^(ADDR_W+1).
- All flags are combinational from the registered pointers, so they reflect the state after the most recent edge.
- Priority per edge is rst_in > flush_in > read/write.
- Write accepted iff write_in && !full_out: mem[wptr] ← data_write_in, then wptr+1.
  - No bypass when full. A write while full is dropped even if a read is accepted in the same cycle.
- Read accepted iff read_in && !empty_out: rptr+1.
  - A read while empty is dropped even if a write is accepted in the same cycle.
- When a write and a read are both accepted in the same cycle, count_out is unchanged.
- FWFT=0: on an accepted read, data_read_out ← mem[rptr] at that edge. Otherwise data_read_out holds its last value.
- FWFT=1: data_read_out = mem[rptr] whenever empty_out=0, and 0 when empty_out=1. read_in pops the word currently shown.
- overflow_out sets at the edge where write_in && full_out is sampled.
- underflow_out sets at the edge where read_in && empty_out is sampled.
- Both error flags hold until rst_in or flush_in.
- flush_in: wptr=rptr=0, both error flags cleared, memory untouched.
  - Any read/write in the flush cycle is ignored.
  - FWFT=0: data_read_out keeps its value.
- Reset values of all outputs:
  - data_read_out=0, count_out=0
  - empty_out=1, full_out=0
  - almost_empty_out=1, almost_full_out=0
  - overflow_out=0, underflow_out=0
- Reset asserted mid-operation discards all contents at the next edge, regardless of write_in/read_in.

## Timing
- Write latency: a write accepted at edge N gives empty_out=0 and count_out+1 after edge N.
  - FWFT=1: the word is visible on data_read_out after edge N.
- FWFT=0 read latency: read_in high at edge N gives data valid after edge N, i.e. one cycle. The earliest read of a word written at edge N is at edge N+1.
- FWFT=1: zero-cycle head visibility. After the pop at edge N, the next word (or 0 if now empty) appears after edge N.
- Full throughput of one write and one read per cycle is sustained at any occupancy 1..DEPTH-1.
- Wrap-around is transparent: pointers roll over 2^(ADDR_W+1) with no bubble. full_out is identified by equal address bits with differing MSBs.

## Test plan
- Fill/drain, DEPTH=16, FWFT=0:
  - Write 0x10,0x01,0x91,…,0x23 (16 words) on consecutive cycles → full_out=1 and count_out=16 after the 16th edge; almost_full_out first high at count 14.
  - Then 16 consecutive reads → identical order, each word one cycle after its read_in; empty_out=1 after the last read.
- Overflow/underflow:
  - With the FIFO full, assert write_in 0xAA together with read_in → the read returns the head word, 0xAA is never stored, overflow_out=1, count_out=15.
  - With the FIFO empty, assert read_in → underflow_out=1 and data_read_out unchanged.
  - flush_in → both flags 0.
- Wrap-around: interleave writes and reads at steady count 3 for 40 cycles, crossing the pointer MSB twice → count_out constant at 3, data in order, full_out never asserts.
- Show-ahead, FWFT=1:
  - Write 0x5A to an empty FIFO → data_read_out=0x5A and empty_out=0 after the same edge.
  - Pop → data_read_out=0 and empty_out=1.
  - Write 0x01,0x02 then hold read_in high → 0x01 and 0x02 on consecutive cycles.
- Flush and reset mid-operation:
  - Flush at count 7 with write_in high → count_out=0 and the written word is discarded.
  - Reset at count 9 with read_in high → all outputs at their reset values after the edge.
  - The next write-then-read returns the new data only.
- Thresholds: AF_THRESH=12, AE_THRESH=4 → almost_empty_out low from count 5 upward, almost_full_out high from count 12 upward, checked in both the fill and the drain direction.
